// File: rtl/uart_load_monitor.sv
// Observes UART loader writes: tracks the load state, word count, checksum and address history,
// flags addresses that do not step sequentially, and muxes a selectable value onto the display word.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_IDLE    | no write accepted since reset; load_done is ignored
// S_LOADING | a load is in progress; accepted writes are accumulated
// S_DONE    | load_done rose; results are held until the next accepted write
module uart_load_monitor #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DISP_W         = 32,
  parameter int CNT_W          = 16,
  parameter int HIST_DEPTH     = 4,
  parameter int ADDR_STEP      = 4,
  parameter int SKIP_ZERO_ADDR = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          load_done,
  input  logic [2:0]                    mode,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_sel,
  input  logic                          freeze,
  output logic [DISP_W-1:0]             disp_value,
  output logic [CNT_W-1:0]              word_count,
  output logic [DATA_W-1:0]             checksum,
  output logic                          seq_err,
  output logic                          busy,
  output logic                          done
);

  localparam int HW = $clog2(HIST_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOADING = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;
  logic [ADDR_W-1:0] history [HIST_DEPTH];
  logic [HW-1:0]     wr_ptr;
  logic              load_done_q;

  logic              accept;
  logic              done_rise;
  logic [HW-1:0]     rd_idx;
  logic [ADDR_W-1:0] hist_rd;
  logic [DISP_W-1:0] disp_mux;

  assign accept    = wr_valid && !((SKIP_ZERO_ADDR != 0) && (wr_addr == '0));
  assign done_rise = load_done && !load_done_q;

  // wr_ptr points at the next free slot, so the newest entry sits one behind it.
  assign rd_idx  = wr_ptr - HW'(1) - hist_sel;
  assign hist_rd = history[rd_idx];

  always_comb begin
    disp_mux = '0;
    case (mode)
      3'd0:    disp_mux = DISP_W'(last_addr);
      3'd1:    disp_mux = DISP_W'(last_data);
      3'd2:    disp_mux = DISP_W'(word_count);
      3'd3:    disp_mux = DISP_W'(checksum);
      3'd4:    disp_mux = DISP_W'(hist_rd);
      3'd5:    disp_mux = DISP_W'({state, seq_err, word_count});
      default: disp_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      last_addr   <= '0;
      last_data   <= '0;
      word_count  <= '0;
      checksum    <= '0;
      seq_err     <= 1'b0;
      wr_ptr      <= '0;
      load_done_q <= 1'b0;
      disp_value  <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) history[i] <= '0;
    end else begin
      load_done_q <= load_done;
      if (!freeze) disp_value <= disp_mux;

      case (state)
        S_IDLE, S_DONE: begin
          // A new load starts from a clean slate with this write as its first word.
          if (accept) begin
            state      <= S_LOADING;
            busy       <= 1'b1;
            done       <= 1'b0;
            last_addr  <= wr_addr;
            last_data  <= wr_data;
            word_count <= CNT_W'(1);
            checksum   <= wr_data;
            seq_err    <= 1'b0;
            wr_ptr     <= HW'(1);
            for (int i = 0; i < HIST_DEPTH; i++) history[i] <= (i == 0) ? wr_addr : '0;
          end
        end
        S_LOADING: begin
          if (accept) begin
            if (wr_addr != last_addr + ADDR_W'(ADDR_STEP)) seq_err <= 1'b1;
            if (word_count != '1) word_count <= word_count + CNT_W'(1);
            last_addr       <= wr_addr;
            last_data       <= wr_data;
            checksum        <= checksum + wr_data;
            history[wr_ptr] <= wr_addr;
            wr_ptr          <= wr_ptr + HW'(1);
          end
          if (done_rise) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_load_monitor.sv
// Scoreboarded bench for uart_load_monitor: two instances (default, and skip-zero with a 3-bit
// counter) share stimulus; a list-based reference model predicts every post-edge output.
module tb_uart_load_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        load_done = 1'b0;
  logic [2:0]  mode = '0;
  logic [1:0]  hist_sel = '0;
  logic        freeze = 1'b0;

  logic [31:0] disp_a, sum_a, disp_b, sum_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;
  logic        seq_a, busy_a, done_a, seq_b, busy_b, done_b;

  always #5 clk = ~clk;

  uart_load_monitor dut_a (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_done(load_done), .mode(mode), .hist_sel(hist_sel), .freeze(freeze),
    .disp_value(disp_a), .word_count(cnt_a), .checksum(sum_a), .seq_err(seq_a),
    .busy(busy_a), .done(done_a)
  );

  uart_load_monitor #(.CNT_W(3), .SKIP_ZERO_ADDR(1)) dut_b (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_done(load_done), .mode(mode), .hist_sel(hist_sel), .freeze(freeze),
    .disp_value(disp_b), .word_count(cnt_b), .checksum(sum_b), .seq_err(seq_b),
    .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, index 0 = dut_a, 1 = dut_b. State: 0 idle, 1 loading, 2 done.
  int          m_state [2];
  logic [31:0] m_hist [2][4];
  logic [31:0] m_last_addr [2], m_last_data [2], m_cnt [2], m_sum [2], m_disp [2];
  logic        m_seq [2], m_ld_prev [2];
  int          m_cw [2] = '{16, 3};
  bit          m_skip [2] = '{1'b0, 1'b1};

  typedef struct {
    logic [31:0] disp [2];
    logic [31:0] cnt [2];
    logic [31:0] sum [2];
    logic        seq [2];
    logic        busy [2];
    logic        done [2];
  } exp_t;

  exp_t sb_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_src(input int d, input logic [2:0] md, input logic [1:0] hs);
    case (md)
      3'd0: return m_last_addr[d];
      3'd1: return m_last_data[d];
      3'd2: return m_cnt[d];
      3'd3: return m_sum[d];
      3'd4: return m_hist[d][hs];
      3'd5: return (32'(m_state[d]) << (m_cw[d] + 1)) | (32'(m_seq[d]) << m_cw[d]) | m_cnt[d];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input int d, input logic rst, input logic wv, input logic [31:0] wa,
                            input logic [31:0] wd, input logic ld, input logic [2:0] md,
                            input logic [1:0] hs, input logic fz);
    logic        acc, rise;
    logic [31:0] cmax;
    if (rst) begin
      m_state[d] = 0; m_last_addr[d] = 0; m_last_data[d] = 0; m_cnt[d] = 0; m_sum[d] = 0;
      m_seq[d] = 0; m_ld_prev[d] = 0; m_disp[d] = 0;
      for (int k = 0; k < 4; k++) m_hist[d][k] = 0;
      return;
    end
    if (!fz) m_disp[d] = model_src(d, md, hs);
    acc  = wv && !(m_skip[d] && wa == 0);
    rise = ld && !m_ld_prev[d];
    cmax = (32'd1 << m_cw[d]) - 1;
    if (m_state[d] != 1) begin
      if (acc) begin
        m_state[d] = 1; m_last_addr[d] = wa; m_last_data[d] = wd; m_cnt[d] = 1; m_sum[d] = wd;
        m_seq[d] = 0;
        m_hist[d][0] = wa;
        for (int k = 1; k < 4; k++) m_hist[d][k] = 0;
      end
    end else begin
      if (acc) begin
        if (wa != m_last_addr[d] + 32'd4) m_seq[d] = 1;
        m_last_addr[d] = wa; m_last_data[d] = wd;
        if (m_cnt[d] < cmax) m_cnt[d] = m_cnt[d] + 1;
        m_sum[d] = m_sum[d] + wd;
        for (int k = 3; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
        m_hist[d][0] = wa;
      end
      if (rise) m_state[d] = 2;
    end
    m_ld_prev[d] = ld;
  endtask

  task automatic drive(input logic rst, input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                       input logic ld, input logic [2:0] md, input logic [1:0] hs, input logic fz);
    exp_t e;
    @(negedge clk);
    reset = rst; wr_valid = wv; wr_addr = wa; wr_data = wd;
    load_done = ld; mode = md; hist_sel = hs; freeze = fz;
    for (int d = 0; d < 2; d++) begin
      model_step(d, rst, wv, wa, wd, ld, md, hs, fz);
      e.disp[d] = m_disp[d]; e.cnt[d] = m_cnt[d]; e.sum[d] = m_sum[d]; e.seq[d] = m_seq[d];
      e.busy[d] = (m_state[d] == 1); e.done[d] = (m_state[d] == 2);
    end
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] wa, input logic [31:0] wd, input logic [2:0] md);
    drive(1'b0, 1'b1, wa, wd, 1'b0, md, 2'd0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("a_disp", disp_a, e.disp[0]);
        chk("a_cnt", {16'h0, cnt_a}, e.cnt[0]);
        chk("a_sum", sum_a, e.sum[0]);
        chk("a_seq", {31'h0, seq_a}, {31'h0, e.seq[0]});
        chk("a_busy", {31'h0, busy_a}, {31'h0, e.busy[0]});
        chk("a_done", {31'h0, done_a}, {31'h0, e.done[0]});
        chk("b_disp", disp_b, e.disp[1]);
        chk("b_cnt", {29'h0, cnt_b}, e.cnt[1]);
        chk("b_sum", sum_b, e.sum[1]);
        chk("b_seq", {31'h0, seq_b}, {31'h0, e.seq[1]});
        chk("b_busy", {31'h0, busy_b}, {31'h0, e.busy[1]});
        chk("b_done", {31'h0, done_b}, {31'h0, e.done[1]});
      end
    end
  end

  logic [31:0] hist_exp [4] = '{32'h14, 32'h10, 32'hC, 32'h8};

  initial begin
    logic [31:0] a;
    logic        ld_r;
    int          wait_cnt;

    // reset state
    drive(1'b1, 1'b1, 32'h10, 32'h5, 1'b0, 3'd0, 2'd0, 1'b0);
    settle();
    chk("rst_cnt", {16'h0, cnt_a}, 32'h0);
    chk("rst_busy", {31'h0, busy_a}, 32'h0);
    chk("rst_disp", disp_a, 32'h0);

    // three sequential writes, checksum displayed
    wr(32'h0, 32'h11, 3'd3); wr(32'h4, 32'h22, 3'd3); wr(32'h8, 32'h33, 3'd3);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd3, 2'd0, 1'b0);
    settle();
    chk("sum3_sum", sum_a, 32'h66);
    chk("sum3_cnt", {16'h0, cnt_a}, 32'h3);
    chk("sum3_seq", {31'h0, seq_a}, 32'h0);
    chk("sum3_disp", disp_a, 32'h66);

    // address gap, done, restart
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'd5, 2'd0, 1'b0);
    wr(32'h0, 32'h1, 3'd5); wr(32'h4, 32'h2, 3'd5); wr(32'hC, 32'h3, 3'd5);
    settle();
    chk("gap_seq", {31'h0, seq_a}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 3'd5, 2'd0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd5, 2'd0, 1'b0);
    settle();
    chk("gap_done", {31'h0, done_a}, 32'h1);
    wr(32'h100, 32'h9, 3'd5);
    settle();
    chk("restart_busy", {31'h0, busy_a}, 32'h1);
    chk("restart_seq", {31'h0, seq_a}, 32'h0);
    chk("restart_cnt", {16'h0, cnt_a}, 32'h1);

    // history readback after six writes
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'd4, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) wr(32'(i * 4), 32'(i + 1), 3'd4);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd4, 2'(k), 1'b0);
      settle();
      chk("hist", disp_a, hist_exp[k]);
    end

    // load_done with a same-cycle write; load_done in idle
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'd2, 2'd0, 1'b0);
    wr(32'h0, 32'h7, 3'd2);
    drive(1'b0, 1'b1, 32'h4, 32'h8, 1'b1, 3'd2, 2'd0, 1'b0);
    settle();
    chk("ldw_cnt", {16'h0, cnt_a}, 32'h2);
    chk("ldw_done", {31'h0, done_a}, 32'h1);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'd2, 2'd0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 3'd2, 2'd0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd2, 2'd0, 1'b0);
    settle();
    chk("idle_ld_done", {31'h0, done_a}, 32'h0);
    chk("idle_ld_busy", {31'h0, busy_a}, 32'h0);

    // freeze holds the display while capture continues
    wr(32'h40, 32'h1, 3'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 2'd0, 1'b0);
    for (int i = 1; i <= 3; i++) drive(1'b0, 1'b1, 32'h40 + 32'(4 * i), 32'h2, 1'b0, 3'd0, 2'd0, 1'b1);
    settle();
    chk("frz_hold", disp_a, 32'h40);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 2'd0, 1'b0);
    settle();
    chk("frz_release", disp_a, 32'h4C);

    // zero-address skip, saturation and reset during a load (dut_b)
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'd2, 2'd0, 1'b0);
    wr(32'h0, 32'h5, 3'd2);
    settle();
    chk("skip_busy", {31'h0, busy_b}, 32'h0);
    chk("skip_cnt", {29'h0, cnt_b}, 32'h0);
    for (int i = 1; i <= 9; i++) wr(32'(i * 4), 32'h1, 3'd2);
    settle();
    chk("sat_cnt", {29'h0, cnt_b}, 32'h7);
    chk("nosat_cnt", {16'h0, cnt_a}, 32'hA);
    drive(1'b1, 1'b1, 32'h28, 32'h1, 1'b0, 3'd2, 2'd0, 1'b0);
    settle();
    chk("rstw_busy", {31'h0, busy_b}, 32'h0);
    chk("rstw_cnt", {29'h0, cnt_b}, 32'h0);
    chk("rstw_sum", sum_b, 32'h0);

    // randomized traffic
    ld_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 19))
        0, 1, 2:  a = 32'h0;
        3, 4, 5:  a = $urandom & 32'hFFFC;
        default:  a = m_last_addr[0] + 32'd4;
      endcase
      if ($urandom_range(0, 5) == 0) ld_r = ~ld_r;
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, a, $urandom, ld_r,
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 2'd0, 1'b0);

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
